ram_request_arbiter: RTL and testbench

- Downstream of the request unit. Consumes its iREN/dREN/dWEN strobes and cache-side addresses, and serialises them onto the single-ported RAM.
- Returns one-cycle ihit/dhit pulses with registered load data, which close the request unit's handshake.
- Data accesses have priority over instruction fetches.
- A watchdog flags RAM transactions that never complete.

---
 rtl/cpu_types_pkg.sv | 22 ++
 rtl/arb_watchdog.sv | 36 +++
 rtl/ram_request_arbiter.sv | 179 +++++++++++++++++
 tb/tb_ram_request_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: machine word, RAM handshake state and the arbiter FSM encoding.
package cpu_types_pkg;

   localparam int CPU_WORD_W = 32;

   typedef logic [CPU_WORD_W-1:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DACC = 2'd1,
      IACC = 2'd2,
      RESP = 2'd3
   } arb_state_t;

endpackage

// File: rtl/arb_watchdog.sv
// Access watchdog: counts cycles while run is high; expire is asserted on the LIMIT-th
// consecutive running cycle. clear returns the count to zero.
module arb_watchdog #(
   parameter int WIDTH = 7,
   parameter int LIMIT = 64
) (
   input  logic CLK,
   input  logic RST,
   input  logic run,
   input  logic clear,
   output logic expire
);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   assign expire = run && (cnt_q == WIDTH'(LIMIT - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (run && !expire) begin
         cnt_d = cnt_q + WIDTH'(1);
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/ram_request_arbiter.sv
// Serialises data and instruction requests onto a single-ported RAM (data first) and returns
// one-cycle hit pulses. Defining ARB_PERF_CNT_EN adds saturating hit/stall counter ports.
module ram_request_arbiter
   import cpu_types_pkg::*;
#(
   parameter int WORD_W      = 32,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              iREN,
   input  logic [WORD_W-1:0] iaddr,
   input  logic              dREN,
   input  logic              dWEN,
   input  logic [WORD_W-1:0] daddr,
   input  logic [WORD_W-1:0] dstore,
   output logic              ihit,
   output logic              dhit,
   output logic [WORD_W-1:0] iload,
   output logic [WORD_W-1:0] dload,
   output logic              ramREN,
   output logic              ramWEN,
   output logic [WORD_W-1:0] ramaddr,
   output logic [WORD_W-1:0] ramstore,
   input  logic [WORD_W-1:0] ramload,
   input  logic [1:0]        ramstate,
   output logic              ramerr
`ifdef ARB_PERF_CNT_EN
   ,
   output logic [31:0]       perf_ihits,
   output logic [31:0]       perf_dhits,
   output logic [31:0]       perf_stall
`endif
);

   localparam int WD_W = $clog2(TIMEOUT_CYC) + 1;

   arb_state_t        state_q;
   logic              op_wr_q;
   logic              ihit_q;
   logic              dhit_q;
   logic              ren_q;
   logic              wen_q;
   logic              ramerr_q;
   logic [WORD_W-1:0] addr_q;
   logic [WORD_W-1:0] store_q;
   logic [WORD_W-1:0] iload_q;
   logic [WORD_W-1:0] dload_q;

   ramstate_t rs;
   logic      in_acc;
   logic      req_held;
   logic      expire;

   assign rs     = ramstate_t'(ramstate);
   assign in_acc = (state_q == DACC) || (state_q == IACC);

   // The line that must stay high for the granted access to remain wanted.
   assign req_held = (state_q == IACC) ? iREN : (op_wr_q ? dWEN : dREN);

   arb_watchdog #(
      .WIDTH (WD_W),
      .LIMIT (TIMEOUT_CYC)
   ) u_watchdog (
      .CLK    (CLK),
      .RST    (RST),
      .run    (in_acc),
      .clear  (!in_acc),
      .expire (expire)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q  <= IDLE;
         op_wr_q  <= 1'b0;
         ihit_q   <= 1'b0;
         dhit_q   <= 1'b0;
         ren_q    <= 1'b0;
         wen_q    <= 1'b0;
         ramerr_q <= 1'b0;
         addr_q   <= '0;
         store_q  <= '0;
         iload_q  <= '0;
         dload_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (dREN || dWEN) begin
                  state_q <= DACC;
                  op_wr_q <= dWEN;
                  ren_q   <= !dWEN;
                  wen_q   <= dWEN;
                  addr_q  <= daddr;
                  store_q <= dstore;
               end else if (iREN) begin
                  state_q <= IACC;
                  op_wr_q <= 1'b0;
                  ren_q   <= 1'b1;
                  wen_q   <= 1'b0;
                  addr_q  <= iaddr;
               end
            end
            DACC, IACC: begin
               // A completing ACCESS outranks a same-cycle fault or request drop.
               if (rs == ACCESS) begin
                  state_q <= RESP;
                  ren_q   <= 1'b0;
                  wen_q   <= 1'b0;
                  if (state_q == IACC) begin
                     ihit_q  <= 1'b1;
                     iload_q <= ramload;
                  end else begin
                     dhit_q <= 1'b1;
                     if (!op_wr_q) begin
                        dload_q <= ramload;
                     end
                  end
               end else if ((rs == ERROR) || expire) begin
                  state_q  <= IDLE;
                  ren_q    <= 1'b0;
                  wen_q    <= 1'b0;
                  ramerr_q <= 1'b1;
               end else if (!req_held) begin
                  state_q <= IDLE;
                  ren_q   <= 1'b0;
                  wen_q   <= 1'b0;
               end
            end
            RESP: begin
               state_q <= IDLE;
               ihit_q  <= 1'b0;
               dhit_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign ihit     = ihit_q;
   assign dhit     = dhit_q;
   assign iload    = iload_q;
   assign dload    = dload_q;
   assign ramREN   = ren_q;
   assign ramWEN   = wen_q;
   assign ramaddr  = addr_q;
   assign ramstore = store_q;
   assign ramerr   = ramerr_q;

`ifdef ARB_PERF_CNT_EN
   logic [31:0] perf_ihits_q;
   logic [31:0] perf_dhits_q;
   logic [31:0] perf_stall_q;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         perf_ihits_q <= '0;
         perf_dhits_q <= '0;
         perf_stall_q <= '0;
      end else begin
         if (ihit_q && (perf_ihits_q != '1)) begin
            perf_ihits_q <= perf_ihits_q + 32'd1;
         end
         if (dhit_q && (perf_dhits_q != '1)) begin
            perf_dhits_q <= perf_dhits_q + 32'd1;
         end
         if (in_acc && (perf_stall_q != '1)) begin
            perf_stall_q <= perf_stall_q + 32'd1;
         end
      end
   end

   assign perf_ihits = perf_ihits_q;
   assign perf_dhits = perf_dhits_q;
   assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_ram_request_arbiter.sv
// Bench for ram_request_arbiter: directed vector table, hand-written corner sequences and a
// randomized run scored against a transaction-level request-unit / memory model.
module tb_ram_request_arbiter;
   import cpu_types_pkg::*;

   logic        CLK = 1'b0;
   logic        RST;
   logic        iREN, dREN, dWEN;
   logic [31:0] iaddr, daddr, dstore;
   logic        ihit, dhit;
   logic [31:0] iload, dload;
   logic        ramREN, ramWEN;
   logic [31:0] ramaddr, ramstore, ramload;
   logic [1:0]  ramstate;
   logic        ramerr;
`ifdef ARB_PERF_CNT_EN
   logic [31:0] perf_ihits, perf_dhits, perf_stall;
`endif

   ram_request_arbiter #(.WORD_W(32), .TIMEOUT_CYC(64)) dut (
      .CLK      (CLK),
      .RST      (RST),
      .iREN     (iREN),
      .iaddr    (iaddr),
      .dREN     (dREN),
      .dWEN     (dWEN),
      .daddr    (daddr),
      .dstore   (dstore),
      .ihit     (ihit),
      .dhit     (dhit),
      .iload    (iload),
      .dload    (dload),
      .ramREN   (ramREN),
      .ramWEN   (ramWEN),
      .ramaddr  (ramaddr),
      .ramstore (ramstore),
      .ramload  (ramload),
      .ramstate (ramstate),
      .ramerr   (ramerr)
`ifdef ARB_PERF_CNT_EN
      ,
      .perf_ihits (perf_ihits),
      .perf_dhits (perf_dhits),
      .perf_stall (perf_stall)
`endif
   );

   always #5 CLK = ~CLK;

   int errors = 0;
   int checks = 0;

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_inputs();
      iREN     = 1'b0;
      dREN     = 1'b0;
      dWEN     = 1'b0;
      ramstate = FREE;
   endtask

   task automatic do_reset();
      RST = 1'b1;
      idle_inputs();
      repeat (2) @(posedge CLK);
      #1;
      RST = 1'b0;
   endtask

   // Directed vectors: outputs observed this cycle, then inputs applied for this cycle.
   typedef struct {
      logic        ir, dr, dw;
      logic [1:0]  rs;
      logic [31:0] da, ds, ia, rl;
      logic        e_ren, e_wen, e_ihit, e_dhit;
      logic [31:0] e_addr, e_store, e_iload, e_dload;
   } vec_t;

   vec_t tbl[12];

   function automatic vec_t row(input logic ir, input logic dr, input logic dw, input logic [1:0] rs,
                                input logic [31:0] da, input logic [31:0] ds, input logic [31:0] ia,
                                input logic [31:0] rl, input logic er, input logic ew, input logic eih,
                                input logic edh, input logic [31:0] ea, input logic [31:0] es,
                                input logic [31:0] eil, input logic [31:0] edl);
      vec_t v;
      v.ir = ir; v.dr = dr; v.dw = dw; v.rs = rs;
      v.da = da; v.ds = ds; v.ia = ia; v.rl = rl;
      v.e_ren = er; v.e_wen = ew; v.e_ihit = eih; v.e_dhit = edh;
      v.e_addr = ea; v.e_store = es; v.e_iload = eil; v.e_dload = edl;
      return v;
   endfunction

   // Reference model state for the randomized phase.
   logic [31:0] ram_mem[32];
   logic [31:0] ref_mem[32];
   bit          d_pend, d_wr, d_both, i_pend;
   logic [31:0] d_a, d_st, i_a;
   bit          prev_d_pend, prev_i_pend;
   bit          txn_act, txn_is_d, acc_now, acc_last, acc_last_d;
   int          wait_n, streak, ntx;

   function automatic int idx(input logic [31:0] a);
      return int'({a[8], a[5:2]});
   endfunction

   initial begin
      iaddr = '0; daddr = '0; dstore = '0; ramload = '0;
      do_reset();

      chk1 ("rst ramerr",     ramerr,   1'b0);
      chk32("rst ramaddr",    ramaddr,  32'h0);
      chk32("rst ramstore",   ramstore, 32'h0);

      tbl[0]  = row(0,1,0,FREE,   32'h40,0,0,0,               0,0,0,0, 0,0,0,0);
      tbl[1]  = row(0,1,0,BUSY,   32'h40,0,0,0,               1,0,0,0, 32'h40,0,0,0);
      tbl[2]  = row(0,1,0,ACCESS, 32'h40,0,0,32'hDEADBEEF,    1,0,0,0, 32'h40,0,0,0);
      tbl[3]  = row(0,0,0,FREE,   0,0,0,0,                    0,0,0,1, 0,0,0,32'hDEADBEEF);
      tbl[4]  = row(1,0,1,FREE,   32'h10,32'h5,32'h80,0,      0,0,0,0, 0,0,0,32'hDEADBEEF);
      tbl[5]  = row(1,0,1,ACCESS, 32'h10,32'h5,32'h80,32'hBAD0BAD0, 0,1,0,0, 32'h10,32'h5,0,32'hDEADBEEF);
      tbl[6]  = row(1,0,0,FREE,   0,0,32'h80,0,               0,0,0,1, 0,0,0,32'hDEADBEEF);
      tbl[7]  = row(1,0,0,FREE,   0,0,32'h80,0,               0,0,0,0, 0,0,0,32'hDEADBEEF);
      tbl[8]  = row(1,0,0,ACCESS, 0,0,32'h80,32'h12345678,    1,0,0,0, 32'h80,0,0,32'hDEADBEEF);
      tbl[9]  = row(1,0,0,FREE,   0,0,32'h80,0,               0,0,1,0, 0,0,32'h12345678,32'hDEADBEEF);
      tbl[10] = row(0,0,0,FREE,   0,0,0,0,                    0,0,0,0, 0,0,32'h12345678,32'hDEADBEEF);
      tbl[11] = row(0,0,0,FREE,   0,0,0,0,                    0,0,0,0, 0,0,32'h12345678,32'hDEADBEEF);

      for (int k = 0; k < 12; k++) begin
         $display("vec %0d: ren=%b wen=%b ihit=%b dhit=%b addr=%h", k, ramREN, ramWEN, ihit, dhit, ramaddr);
         chk1 ($sformatf("vec%0d ramREN", k), ramREN, tbl[k].e_ren);
         chk1 ($sformatf("vec%0d ramWEN", k), ramWEN, tbl[k].e_wen);
         chk1 ($sformatf("vec%0d ihit", k),   ihit,   tbl[k].e_ihit);
         chk1 ($sformatf("vec%0d dhit", k),   dhit,   tbl[k].e_dhit);
         chk1 ($sformatf("vec%0d ramerr", k), ramerr, 1'b0);
         if (tbl[k].e_ren || tbl[k].e_wen)
            chk32($sformatf("vec%0d ramaddr", k), ramaddr, tbl[k].e_addr);
         if (tbl[k].e_wen)
            chk32($sformatf("vec%0d ramstore", k), ramstore, tbl[k].e_store);
         chk32($sformatf("vec%0d iload", k), iload, tbl[k].e_iload);
         chk32($sformatf("vec%0d dload", k), dload, tbl[k].e_dload);
         iREN = tbl[k].ir; dREN = tbl[k].dr; dWEN = tbl[k].dw; ramstate = tbl[k].rs;
         daddr = tbl[k].da; dstore = tbl[k].ds; iaddr = tbl[k].ia; ramload = tbl[k].rl;
         tick();
      end
`ifdef ARB_PERF_CNT_EN
      chk32("perf dhits", perf_dhits, 32'd2);
      chk32("perf ihits", perf_ihits, 32'd1);
      chk32("perf stall", perf_stall, 32'd4);
`endif

      // Asynchronous reset in the middle of a data access.
      dREN = 1'b1; daddr = 32'h44; ramstate = BUSY;
      tick();
      chk1("rstmid pre ramREN", ramREN, 1'b1);
      #2 RST = 1'b1;
      #1;
      $display("rstmid: ren=%b addr=%h dload=%h", ramREN, ramaddr, dload);
      chk1 ("rstmid ramREN",  ramREN,  1'b0);
      chk32("rstmid ramaddr", ramaddr, 32'h0);
      chk32("rstmid dload",   dload,   32'h0);
      chk32("rstmid iload",   iload,   32'h0);
      chk1 ("rstmid dhit",    dhit,    1'b0);
`ifdef ARB_PERF_CNT_EN
      chk32("rstmid perf stall", perf_stall, 32'd0);
      chk32("rstmid perf dhits", perf_dhits, 32'd0);
`endif
      do_reset();
      chk1("rstmid after dhit", dhit, 1'b0);

      // RAM reports ERROR during a fetch.
      iREN = 1'b1; iaddr = 32'h84;
      tick();
      ramstate = ERROR;
      tick();
      $display("error: ramerr=%b ihit=%b ren=%b", ramerr, ihit, ramREN);
      chk1("err ramerr", ramerr, 1'b1);
      chk1("err ihit",   ihit,   1'b0);
      chk1("err ramREN", ramREN, 1'b0);
      idle_inputs();
      tick();
      chk1("err ihit later", ihit, 1'b0);
      do_reset();
      chk1("err cleared by rst", ramerr, 1'b0);

      // Fetch that never sees ACCESS: abort after 64 cycles in the access state.
      iREN = 1'b1; iaddr = 32'h88; ramstate = BUSY;
      for (int k = 1; k <= 64; k++) begin
         tick();
         chk1($sformatf("to c%0d ramREN", k), ramREN, 1'b1);
         chk1($sformatf("to c%0d ihit", k),   ihit,   1'b0);
         chk1($sformatf("to c%0d ramerr", k), ramerr, 1'b0);
      end
      tick();
      $display("timeout: ramerr=%b ren=%b ihit=%b", ramerr, ramREN, ihit);
      chk1("to ramerr", ramerr, 1'b1);
      chk1("to ramREN", ramREN, 1'b0);
      chk1("to ihit",   ihit,   1'b0);
      idle_inputs();
      tick();
      chk1("to ihit later", ihit, 1'b0);

      // A normal access still completes while ramerr stays set.
      dREN = 1'b1; daddr = 32'h48;
      tick();
      ramstate = ACCESS; ramload = 32'hCAFEF00D;
      tick();
      $display("post-timeout read: dhit=%b dload=%h ramerr=%b", dhit, dload, ramerr);
      chk1 ("post dhit",   dhit,   1'b1);
      chk32("post dload",  dload,  32'hCAFEF00D);
      chk1 ("post ramerr", ramerr, 1'b1);
      idle_inputs();
      tick();

      // Request dropped after one cycle of DACC, before ACCESS.
      dREN = 1'b1; daddr = 32'h4C; ramstate = BUSY;
      tick();
      chk1("abort pre ramREN", ramREN, 1'b1);
      dREN = 1'b0;
      tick();
      $display("abort: ren=%b wen=%b dhit=%b", ramREN, ramWEN, dhit);
      chk1("abort ramREN", ramREN, 1'b0);
      chk1("abort ramWEN", ramWEN, 1'b0);
      chk1("abort dhit",   dhit,   1'b0);
      idle_inputs();
      tick();
      chk1 ("abort dhit later", dhit,  1'b0);
      chk32("abort dload hold", dload, 32'hCAFEF00D);

      // Drop coinciding with ACCESS still completes.
      dREN = 1'b1; daddr = 32'h50;
      tick();
      dREN = 1'b0; ramstate = ACCESS; ramload = 32'h0000600D;
      tick();
      $display("drop+access: dhit=%b dload=%h", dhit, dload);
      chk1 ("dropacc dhit",  dhit,  1'b1);
      chk32("dropacc dload", dload, 32'h0000600D);
      idle_inputs();
      tick();

      // Randomized phase against the transaction-level model.
      do_reset();
      for (int k = 0; k < 32; k++) begin
         ram_mem[k] = (32'(k) * 32'h01010101) ^ 32'hA5A5A5A5;
         ref_mem[k] = ram_mem[k];
      end
      d_pend = 0; i_pend = 0; prev_d_pend = 0; prev_i_pend = 0;
      txn_act = 0; acc_last = 0; acc_last_d = 0; streak = 0; ntx = 0;
      d_a = 0; d_st = 0; i_a = 0; d_wr = 0; d_both = 0; wait_n = 0; txn_is_d = 0;

      for (int cyc = 0; cyc < 600; cyc++) begin
         chk1("rnd ihit",   ihit,   acc_last && !acc_last_d);
         chk1("rnd dhit",   dhit,   acc_last && acc_last_d);
         chk1("rnd ramerr", ramerr, 1'b0);
         if (acc_last && acc_last_d) begin
            if (!d_wr) chk32("rnd dload", dload, ref_mem[idx(d_a)]);
            else       ref_mem[idx(d_a)] = d_st;
            $display("txn %0d: data %s addr=%h data=%h", ntx, d_wr ? "write" : "read ", d_a,
                     d_wr ? d_st : ref_mem[idx(d_a)]);
            ntx++;
            d_pend = 0;
         end
         if (acc_last && !acc_last_d) begin
            chk32("rnd iload", iload, ref_mem[idx(i_a)]);
            $display("txn %0d: fetch      addr=%h data=%h", ntx, i_a, ref_mem[idx(i_a)]);
            ntx++;
            i_pend = 0;
         end

         if (acc_last) begin
            chk1("rnd strobe after access", ramREN || ramWEN, 1'b0);
         end else if ((ramREN || ramWEN) && !txn_act) begin
            chk1("rnd grant has request", prev_d_pend || prev_i_pend, 1'b1);
            txn_is_d = prev_d_pend;
            txn_act  = 1;
            wait_n   = int'($urandom_range(0, 3));
         end else if (!(ramREN || ramWEN) && txn_act) begin
            chk1("rnd strobe held", 1'b0, 1'b1);
            txn_act = 0;
         end
         if (txn_act) begin
            chk32("rnd ramaddr", ramaddr, txn_is_d ? d_a : i_a);
            chk1 ("rnd ramWEN",  ramWEN,  txn_is_d && d_wr);
            chk1 ("rnd ramREN",  ramREN,  !(txn_is_d && d_wr));
            if (txn_is_d && d_wr) chk32("rnd ramstore", ramstore, d_st);
         end

         if (!(ramREN || ramWEN) && (prev_d_pend || prev_i_pend)) begin
            streak++;
            chk1("rnd grant latency", streak > 2, 1'b0);
         end else begin
            streak = 0;
         end

         acc_now = 0;
         if (txn_act) begin
            if (wait_n == 0) begin
               ramstate = ACCESS;
               ramload  = ram_mem[idx(ramaddr)];
               if (ramWEN) ram_mem[idx(ramaddr)] = ramstore;
               acc_now    = 1;
               acc_last_d = txn_is_d;
               txn_act    = 0;
            end else begin
               ramstate = BUSY;
               wait_n--;
            end
         end else begin
            ramstate = FREE;
            ramload  = $urandom;
         end

         if (!d_pend && ($urandom_range(0, 2) == 0)) begin
            d_pend = 1;
            d_wr   = $urandom_range(0, 1) == 1;
            d_both = d_wr && ($urandom_range(0, 3) == 0);
            d_a    = 32'($urandom_range(0, 15)) << 2;
            d_st   = $urandom;
         end
         if (!i_pend && ($urandom_range(0, 2) == 0)) begin
            i_pend = 1;
            i_a    = 32'h100 + (32'($urandom_range(0, 15)) << 2);
         end
         dREN   = d_pend && (!d_wr || d_both);
         dWEN   = d_pend && d_wr;
         daddr  = d_pend ? d_a : $urandom;
         dstore = d_pend ? d_st : $urandom;
         iREN   = i_pend;
         iaddr  = i_pend ? i_a : $urandom;

         prev_d_pend = d_pend;
         prev_i_pend = i_pend;
         acc_last    = acc_now;
         tick();
      end
      chk1("rnd enough transactions", ntx > 40, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
